// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer: DEPTH-entry FIFO carrying an opaque WIDTH-bit payload.
// Latency: a push into an empty buffer appears on valid_o/data_o after the same edge.
// Backpressure: ready_o drops when full, stalled, flushing or in reset; no full-buffer pass-through.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   valid_i/ready_o/data_i  upstream handshake and payload (push = valid_i & ready_o)
//   valid_o/ready_i/data_o  downstream handshake and head payload (RESET_VAL when empty)
//   stall_i                 hazard hold: no push, no pop, contents frozen
//   flush_i                 synchronous discard of all entries (wins over stall)
//   count_o                 current occupancy
//   bubble_cnt_o, stall_cnt_o  saturating 16-bit statistics, present only when
//                              the PIPE_BUF_STATS_EN macro is defined
module pipe_stage_buf #(
    parameter int unsigned      WIDTH     = 64,
    parameter int unsigned      DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [WIDTH-1:0]           data_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [WIDTH-1:0]           data_o,
    input  logic                       stall_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef PIPE_BUF_STATS_EN
    ,
    output logic [15:0]                bubble_cnt_o,
    output logic [15:0]                stall_cnt_o
`endif
);

    localparam int unsigned CW = $clog2(DEPTH+1);
    // Keep pointers at least one bit wide so DEPTH=1 still elaborates.
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign ready_o = (count < CW'(DEPTH)) & ~stall_i & ~flush_i & rst_i;
    assign valid_o = (count != '0);
    // Output is a mux of registered state only; empty presents the NOP bubble.
    assign data_o  = valid_o ? mem[rd_ptr] : RESET_VAL;
    assign count_o = count;

    assign push = valid_i & ready_o;
    assign pop  = valid_o & ready_i & ~stall_i & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= RESET_VAL;
            end
        end else if (flush_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            // stall_i is already folded into push and pop.
            if (push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef PIPE_BUF_STATS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_cnt_o <= '0;
            stall_cnt_o  <= '0;
        end else begin
            if (!valid_o && ready_i && bubble_cnt_o != 16'hFFFF) begin
                bubble_cnt_o <= bubble_cnt_o + 16'd1;
            end
            if (stall_i && stall_cnt_o != 16'hFFFF) begin
                stall_cnt_o <= stall_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a DEPTH=2 instance (RESET_VAL=0) and a DEPTH=3
// instance (RESET_VAL=16'hDEAD) share stimulus; each is compared every cycle
// against a queue-based reference model, plus hand-computed table rows.
module tb_pipe_stage_buf;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [15:0] data_i;
    logic        ready_i;
    logic        stall_i;
    logic        flush_i;

    logic        r2o, v2o, r3o, v3o;
    logic [15:0] d2o, d3o;
    logic [1:0]  c2o, c3o;
`ifdef PIPE_BUF_STATS_EN
    logic [15:0] bub2o, stl2o, bub3o, stl3o;
`endif

    always #5 clk_i = ~clk_i;

    pipe_stage_buf #(.WIDTH(16), .DEPTH(2), .RESET_VAL(16'h0000)) u_d2 (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(r2o), .data_i(data_i),
        .valid_o(v2o), .ready_i(ready_i), .data_o(d2o), .stall_i(stall_i),
        .flush_i(flush_i), .count_o(c2o)
`ifdef PIPE_BUF_STATS_EN
        , .bubble_cnt_o(bub2o), .stall_cnt_o(stl2o)
`endif
    );

    pipe_stage_buf #(.WIDTH(16), .DEPTH(3), .RESET_VAL(16'hDEAD)) u_d3 (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(r3o), .data_i(data_i),
        .valid_o(v3o), .ready_i(ready_i), .data_o(d3o), .stall_i(stall_i),
        .flush_i(flush_i), .count_o(c3o)
`ifdef PIPE_BUF_STATS_EN
        , .bubble_cnt_o(bub3o), .stall_cnt_o(stl3o)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] q2[$];
    logic [15:0] q3[$];
    logic [15:0] m_bub2 = 0, m_bub3 = 0, m_stl = 0;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic model_clear();
        q2.delete();
        q3.delete();
        m_bub2 = 0;
        m_bub3 = 0;
        m_stl  = 0;
    endtask

    // Apply one clock edge's worth of rules to the model, using pre-edge inputs.
    task automatic model_edge();
        bit pop2, pop3, push2, push3;
        if (!rst_i) begin
            model_clear();
        end else begin
            if (q2.size() == 0 && ready_i) m_bub2 = sat_inc(m_bub2);
            if (q3.size() == 0 && ready_i) m_bub3 = sat_inc(m_bub3);
            if (stall_i) m_stl = sat_inc(m_stl);
            if (flush_i) begin
                q2.delete();
                q3.delete();
            end else if (!stall_i) begin
                pop2  = (q2.size() != 0) && ready_i;
                pop3  = (q3.size() != 0) && ready_i;
                push2 = valid_i && (q2.size() < 2);
                push3 = valid_i && (q3.size() < 3);
                if (pop2)  void'(q2.pop_front());
                if (pop3)  void'(q3.pop_front());
                if (push2) q2.push_back(data_i);
                if (push3) q3.push_back(data_i);
            end
        end
    endtask

    task automatic check_all();
        bit rd_ok;
        rd_ok = rst_i && !stall_i && !flush_i;
        chk("d2_valid", 32'(v2o), 32'(q2.size() != 0));
        chk("d2_data",  32'(d2o), (q2.size() != 0) ? 32'(q2[0]) : 32'h0);
        chk("d2_count", 32'(c2o), 32'(q2.size()));
        chk("d2_ready", 32'(r2o), 32'(rd_ok && q2.size() < 2));
        chk("d3_valid", 32'(v3o), 32'(q3.size() != 0));
        chk("d3_data",  32'(d3o), (q3.size() != 0) ? 32'(q3[0]) : 32'hDEAD);
        chk("d3_count", 32'(c3o), 32'(q3.size()));
        chk("d3_ready", 32'(r3o), 32'(rd_ok && q3.size() < 3));
`ifdef PIPE_BUF_STATS_EN
        chk("d2_bubble", 32'(bub2o), 32'(m_bub2));
        chk("d3_bubble", 32'(bub3o), 32'(m_bub3));
        chk("d2_stall",  32'(stl2o), 32'(m_stl));
        chk("d3_stall",  32'(stl3o), 32'(m_stl));
`endif
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    // Let the combinational outputs settle; async reset takes effect at once.
    task automatic settle();
        #1;
        if (!rst_i) model_clear();
    endtask

    // ---------------- directed table (DEPTH=2 expectations by hand) ----------------
    typedef struct {
        logic        rst, v;
        logic [15:0] d;
        logic        r, s, f;
        logic        ev;
        logic [15:0] ed;
        logic [1:0]  ec;
        logic        er;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic rst, input logic v, input logic [15:0] d,
                                input logic r, input logic s, input logic f,
                                input logic ev, input logic [15:0] ed, input int ec,
                                input logic er);
        vec_t x;
        x.rst = rst; x.v = v; x.d = d; x.r = r; x.s = s; x.f = f;
        x.ev = ev; x.ed = ed; x.ec = 2'(ec); x.er = er;
        return x;
    endfunction

    initial begin
        rst_i = 1'b0; valid_i = 1'b0; data_i = '0; ready_i = 1'b0;
        stall_i = 1'b0; flush_i = 1'b0;

        //            rst v  data     r  s  f   ev ed       ec er
        // fill/drain: A,B accepted, C refused, then A,B drain, then bubble
        tbl[0]  = mk(1, 1, 16'h00A1, 0, 0, 0,  0, 16'h0000, 0, 1);
        tbl[1]  = mk(1, 1, 16'h00B2, 0, 0, 0,  1, 16'h00A1, 1, 1);
        tbl[2]  = mk(1, 1, 16'h00C3, 0, 0, 0,  1, 16'h00A1, 2, 0);
        tbl[3]  = mk(1, 0, 16'h0000, 1, 0, 0,  1, 16'h00A1, 2, 0);
        tbl[4]  = mk(1, 0, 16'h0000, 1, 0, 0,  1, 16'h00B2, 1, 1);
        tbl[5]  = mk(1, 0, 16'h0000, 1, 0, 0,  0, 16'h0000, 0, 1);
        // stall: X held for 3 cycles, popped on first edge after release
        tbl[6]  = mk(1, 1, 16'h00C4, 0, 0, 0,  0, 16'h0000, 0, 1);
        tbl[7]  = mk(1, 1, 16'h00D5, 1, 1, 0,  1, 16'h00C4, 1, 0);
        tbl[8]  = mk(1, 1, 16'h00D5, 1, 1, 0,  1, 16'h00C4, 1, 0);
        tbl[9]  = mk(1, 1, 16'h00D5, 1, 1, 0,  1, 16'h00C4, 1, 0);
        tbl[10] = mk(1, 0, 16'h0000, 1, 0, 0,  1, 16'h00C4, 1, 1);
        tbl[11] = mk(1, 0, 16'h0000, 0, 0, 0,  0, 16'h0000, 0, 1);
        // flush beats stall and a same-cycle push/pop at count=2
        tbl[12] = mk(1, 1, 16'h00E1, 0, 0, 0,  0, 16'h0000, 0, 1);
        tbl[13] = mk(1, 1, 16'h00E2, 0, 0, 0,  1, 16'h00E1, 1, 1);
        tbl[14] = mk(1, 1, 16'h00E3, 1, 1, 1,  1, 16'h00E1, 2, 0);
        tbl[15] = mk(1, 0, 16'h0000, 0, 0, 0,  0, 16'h0000, 0, 1);
        // async reset at count=2, observed before any clock edge
        tbl[16] = mk(1, 1, 16'h00F1, 0, 0, 0,  0, 16'h0000, 0, 1);
        tbl[17] = mk(1, 1, 16'h00F2, 0, 0, 0,  1, 16'h00F1, 1, 1);
        tbl[18] = mk(0, 1, 16'h00F3, 1, 0, 0,  0, 16'h0000, 0, 0);
        tbl[19] = mk(1, 0, 16'h0000, 0, 0, 0,  0, 16'h0000, 0, 1);

        // Reset state
        tick();
        tick();
        settle();
        chk("rst_valid", 32'(v2o), 32'h0);
        chk("rst_data3", 32'(d3o), 32'hDEAD);
        chk("rst_ready", 32'(r2o), 32'h0);
        check_all();

        for (int i = 0; i < NV; i++) begin
            rst_i = tbl[i].rst; valid_i = tbl[i].v; data_i = tbl[i].d;
            ready_i = tbl[i].r; stall_i = tbl[i].s; flush_i = tbl[i].f;
            settle();
            chk($sformatf("row%0d_valid", i), 32'(v2o), 32'(tbl[i].ev));
            chk($sformatf("row%0d_data",  i), 32'(d2o), 32'(tbl[i].ed));
            chk($sformatf("row%0d_count", i), 32'(c2o), 32'(tbl[i].ec));
            chk($sformatf("row%0d_ready", i), 32'(r2o), 32'(tbl[i].er));
            check_all();
            tick();
        end

        // Wrap on DEPTH=3: one entry in flight, 10 push/pop pairs
        valid_i = 1'b1; data_i = 16'h0100; ready_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        settle();
        check_all();
        tick();
        for (int k = 1; k <= 10; k++) begin
            valid_i = 1'b1; data_i = 16'h0100 + 16'(k); ready_i = 1'b1;
            settle();
            chk($sformatf("wrap%0d_count", k), 32'(c3o), 32'h1);
            chk($sformatf("wrap%0d_data",  k), 32'(d3o), 32'(16'h0100 + 16'(k - 1)));
            check_all();
            tick();
        end
        valid_i = 1'b0;
        settle();
        check_all();
        tick();
        settle();
        chk("wrap_empty_data", 32'(d3o), 32'hDEAD);
        check_all();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst_i   = ($urandom_range(0, 63) != 0);
            valid_i = 1'($urandom);
            data_i  = 16'($urandom);
            ready_i = ($urandom_range(0, 3) != 0);
            stall_i = ($urandom_range(0, 7) == 0);
            flush_i = ($urandom_range(0, 15) == 0);
            settle();
            check_all();
            tick();
        end

`ifdef PIPE_BUF_STATS_EN
        // Stall counter saturation, and flush leaves the counters alone
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; stall_i = 1'b1; flush_i = 1'b0;
        repeat (70000) tick();
        settle();
        chk("stall_sat", 32'(stl2o), 32'hFFFF);
        check_all();
        flush_i = 1'b1;
        repeat (3) tick();
        settle();
        chk("stall_sat_hold", 32'(stl3o), 32'hFFFF);
        check_all();
        // Empty buffer with ready_i=1 for 5 cycles adds 5 bubbles
        stall_i = 1'b0; flush_i = 1'b1;
        tick();
        flush_i = 1'b0; ready_i = 1'b1;
        begin
            logic [15:0] b0;
            b0 = m_bub2;
            repeat (5) tick();
            settle();
            chk("bubble_plus5", 32'(bub2o), 32'(b0 + 16'd5));
        end
        check_all();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
